// File: rtl/data_mem_responder.sv
// Multi-cycle word memory target. Each access holds stall for LATENCY+1 cycles, then pulses done for one cycle.
// Back-to-back requests are accepted in the DONE cycle. Unaligned requests raise err and are dropped.
module data_mem_responder #(
    parameter int MEM_DEPTH_LOG2 = 8,
    parameter int LATENCY        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        stall,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int         DEPTH  = 1 << MEM_DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]                r_state;
    logic [3:0]                r_cnt;
    logic                      r_wr;
    logic [MEM_DEPTH_LOG2-1:0] r_idx;
    logic [15:0]               r_wdat;
    logic [15:0]               r_mem [DEPTH];

    logic w_ready;
    logic w_accept;
    logic w_fire;
    logic w_unused_addr;

    assign w_ready  = (r_state != S_WAIT);
    assign w_accept = w_ready & enable & ~addr[0];
    assign w_fire   = (r_state == S_WAIT) && (r_cnt == 4'd0);

    assign stall = ~w_ready | w_accept;
    assign err   = w_ready & enable & addr[0];
    assign done  = (r_state == S_DONE);

    // Address bits above the array index are ignored, so accesses wrap.
    assign w_unused_addr = ^addr[15:MEM_DEPTH_LOG2+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_wr     <= 1'b0;
            r_idx    <= '0;
            r_wdat   <= 16'd0;
            data_out <= 16'd0;
        end else if (w_accept) begin
            r_state <= S_WAIT;
            r_cnt   <= CNT_INIT;
            r_wr    <= wr;
            r_idx   <= addr[MEM_DEPTH_LOG2:1];
            r_wdat  <= data_in;
        end else if (r_state == S_WAIT) begin
            if (w_fire) begin
                r_state <= S_DONE;
                if (!r_wr) begin
                    data_out <= r_mem[r_idx];
                end
            end else begin
                r_cnt <= r_cnt - 4'd1;
            end
        end else begin
            r_state <= S_IDLE;
        end
    end

    // No reset on the array; a reset during WAIT leaves the state IDLE so the write never fires.
    always_ff @(posedge clk) begin
        if (w_fire && r_wr) begin
            r_mem[r_idx] <= r_wdat;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: scoreboard on done for the LATENCY=3 instance, plus LATENCY=1/15 sweep instances.
module tb_data_mem_responder;

    localparam int LAT = 3;

    typedef struct {
        int          cyc;
        logic [15:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, wr;
    logic [15:0] addr, data_in, data_out;
    logic        stall, done, err;

    logic        s_en [2];
    logic        s_wr [2];
    logic [15:0] s_addr [2];
    logic [15:0] s_din [2];
    logic [15:0] s_dout [2];
    logic        s_stall [2];
    logic        s_done [2];
    logic        s_err [2];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t exp_q [$];
    exp_t mon_e;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.MEM_DEPTH_LOG2(8), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(data_out), .stall(stall), .done(done), .err(err)
    );

    data_mem_responder #(.MEM_DEPTH_LOG2(8), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .enable(s_en[0]), .wr(s_wr[0]), .addr(s_addr[0]), .data_in(s_din[0]),
        .data_out(s_dout[0]), .stall(s_stall[0]), .done(s_done[0]), .err(s_err[0])
    );

    data_mem_responder #(.MEM_DEPTH_LOG2(8), .LATENCY(15)) u_l15 (
        .clk(clk), .rst(rst), .enable(s_en[1]), .wr(s_wr[1]), .addr(s_addr[1]), .data_in(s_din[1]),
        .data_out(s_dout[1]), .stall(s_stall[1]), .done(s_done[1]), .err(s_err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the next queued expectation in cycle and data.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done_spurious actual=1 required=0 at cycle %0d", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_cycle", cyc, mon_e.cyc);
                chk("done_data_out", data_out, mon_e.dat);
            end
            chk("done_single", prev_done, 0);
        end
        prev_done = done;
    end

    // Called at posedge+1 with the DUT in IDLE or DONE; returns at posedge+1 of the DONE cycle.
    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp_dout);
        enable  = 1'b1;
        wr      = w;
        addr    = a;
        data_in = d;
        exp_q.push_back('{cyc + LAT + 1, exp_dout});
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            chk("stall_hold", stall, 1);
            chk("err_busy", err, 0);
            @(posedge clk);
            #1;
            if (k < LAT) begin
                wr      = ~w;
                addr    = a ^ 16'h0023;
                data_in = ~d;
            end
        end
    endtask

    task automatic idle();
        enable  = 1'b0;
        addr    = 16'h0000;
        @(negedge clk);
        chk("stall_idle", stall, 0);
        chk("err_idle", err, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input int i, input int lat, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] exp_dout);
        int n;
        n = 0;
        s_en[i]   = 1'b1;
        s_wr[i]   = w;
        s_addr[i] = a;
        s_din[i]  = d;
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            if (!s_stall[i]) break;
            n++;
            @(posedge clk);
            #1;
            s_en[i] = 1'b0;
        end
        chk("sweep_stall_cycles", n, lat + 1);
        chk("sweep_done", s_done[i], 1);
        chk("sweep_data_out", s_dout[i], exp_dout);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("sweep_done_drop", s_done[i], 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        enable = 1'b0; wr = 1'b0; addr = 16'h0; data_in = 16'h0;
        for (int i = 0; i < 2; i++) begin
            s_en[i] = 1'b0; s_wr[i] = 1'b0; s_addr[i] = 16'h0; s_din[i] = 16'h0;
        end
        #1;
        chk("rst_data_out", data_out, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic write then read
        access(1'b1, 16'h0010, 16'hBEEF, 16'h0000);
        idle();
        access(1'b0, 16'h0010, 16'h0000, 16'hBEEF);
        idle();

        // Unaligned read and write: err, no stall, no done, no array change
        enable = 1'b1; wr = 1'b0; addr = 16'h0011;
        @(negedge clk);
        chk("unaligned_rd_err", err, 1);
        chk("unaligned_rd_stall", stall, 0);
        @(posedge clk);
        #1;
        wr = 1'b1; data_in = 16'hDEAD;
        @(negedge clk);
        chk("unaligned_wr_err", err, 1);
        chk("unaligned_wr_stall", stall, 0);
        @(posedge clk);
        #1;
        idle();
        access(1'b0, 16'h0010, 16'h0000, 16'hBEEF);
        idle();

        // Back-to-back: read accepted in the DONE cycle of the write
        access(1'b1, 16'h0020, 16'h1234, 16'hBEEF);
        access(1'b0, 16'h0020, 16'h0000, 16'h1234);
        idle();

        // Reset in the second WAIT cycle aborts the write
        access(1'b1, 16'h0030, 16'h5555, 16'h1234);
        idle();
        enable = 1'b1; wr = 1'b1; addr = 16'h0030; data_in = 16'hAAAA;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_data_out", data_out, 0);
        chk("abort_stall", stall, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        access(1'b0, 16'h0030, 16'h0000, 16'h5555);
        idle();

        // Address wrap modulo 256 words
        access(1'b1, 16'h0202, 16'h0F0F, 16'h5555);
        idle();
        access(1'b0, 16'h0002, 16'h0000, 16'h0F0F);
        idle();
        idle();

        // Latency sweep
        sweep(0, 1, 1'b1, 16'h0040, 16'h7777, 16'h0000);
        sweep(0, 1, 1'b0, 16'h0040, 16'h0000, 16'h7777);
        sweep(1, 15, 1'b1, 16'h0050, 16'h9999, 16'h0000);
        sweep(1, 15, 1'b0, 16'h0050, 16'h0000, 16'h9999);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
